// File: rtl/sram_compiled_pkg.sv
// Shared constants and types for the compiled SRAM array slice.
// Optional feature macro: SRAM_WRITE_THROUGH_EN (write-first dout on write edges).
package sram_compiled_pkg;

    localparam int ADDR_W = 11;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 2 ** ADDR_W;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;

endpackage : sram_compiled_pkg

// File: rtl/sram_compiled_core.sv
// Storage array and registered read port of the compiled SRAM.
// Macro SRAM_WRITE_THROUGH_EN: when defined, a write edge with sense_en=1
// loads din into dout (write-first); otherwise dout holds on every write edge.
module sram_compiled_core
    import sram_compiled_pkg::*;
#(
    parameter int ADDR_W = sram_compiled_pkg::ADDR_W,
    parameter int DATA_W = sram_compiled_pkg::DATA_W,
    parameter int DEPTH  = sram_compiled_pkg::DEPTH
) (
    input  logic              clk_1,
    input  logic              rst_n_sync,
    input  logic              write_en,
    input  logic              sense_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] dout_d;
    logic [DATA_W-1:0] dout_q;
    logic              mem_we;

    // Decide the next read-register value and whether the array is written.
    always_comb begin
        // NOTE: defaults first, so every path assigns each output and no latch is inferred.
        dout_d = dout_q;
        mem_we = rst_n_sync & write_en;
        if (write_en) begin
`ifdef SRAM_WRITE_THROUGH_EN
            if (sense_en) begin
                dout_d = din;
            end
`endif
        end else if (sense_en) begin
            dout_d = mem_q[addr];
        end
    end

    // Array write port; the old word is never routed to dout during a write.
    // NOTE: the array has no reset so it maps onto RAM; reset only blocks writes.
    always_ff @(posedge clk_1) begin
        if (mem_we) begin
            mem_q[addr] <= din;
        end
    end

    // Read register with asynchronous clear.
    // NOTE: sequential state uses non-blocking assignments to avoid simulation races.
    always_ff @(posedge clk_1 or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            dout_q <= '0;
        end else begin
            dout_q <= dout_d;
        end
    end

    assign dout = dout_q;

endmodule : sram_compiled_core

// File: rtl/sram_compiled_array.sv
// Compiled SRAM array top: discrete bit-level pins packed into vectors around
// one sram_compiled_core. Several instances sharing addr/clock/enables form wider words.
// Macro SRAM_WRITE_THROUGH_EN selects write-first dout behaviour (see core).
module sram_compiled_array
    import sram_compiled_pkg::*;
#(
    parameter int ADDR_W = sram_compiled_pkg::ADDR_W,
    parameter int DATA_W = sram_compiled_pkg::DATA_W,
    parameter int DEPTH  = sram_compiled_pkg::DEPTH
) (
    input  logic clk_1,
    input  logic rst_n_sync,
    input  logic write_en,
    input  logic sense_en,
    input  logic addr10,
    input  logic addr9,
    input  logic addr8,
    input  logic addr7,
    input  logic addr6,
    input  logic addr5,
    input  logic addr4,
    input  logic addr3,
    input  logic addr2,
    input  logic addr1,
    input  logic addr0,
    input  logic din7,
    input  logic din6,
    input  logic din5,
    input  logic din4,
    input  logic din3,
    input  logic din2,
    input  logic din1,
    input  logic din0,
    output logic dout7,
    output logic dout6,
    output logic dout5,
    output logic dout4,
    output logic dout3,
    output logic dout2,
    output logic dout1,
    output logic dout0
);

    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] din;
    logic [DATA_W-1:0] dout;

    assign addr = {addr10, addr9, addr8, addr7, addr6, addr5,
                   addr4, addr3, addr2, addr1, addr0};
    assign din  = {din7, din6, din5, din4, din3, din2, din1, din0};
    assign {dout7, dout6, dout5, dout4, dout3, dout2, dout1, dout0} = dout;

    sram_compiled_core #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_core (
        .clk_1      (clk_1),
        .rst_n_sync (rst_n_sync),
        .write_en   (write_en),
        .sense_en   (sense_en),
        .addr       (addr),
        .din        (din),
        .dout       (dout)
    );

endmodule : sram_compiled_array

// File: tb/tb_sram_compiled_array.sv
// Directed self-checking bench for sram_compiled_array.
// Expectations follow SRAM_WRITE_THROUGH_EN when it is defined for the build.
module tb_sram_compiled_array;
    import sram_compiled_pkg::*;

    logic  clk_1      = 1'b0;
    logic  rst_n_sync = 1'b0;
    logic  write_en   = 1'b0;
    logic  sense_en   = 1'b0;
    addr_t a          = '0;
    data_t d          = '0;
    wire [7:0] dout;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk_1 = ~clk_1;

    sram_compiled_array dut (
        .clk_1      (clk_1),
        .rst_n_sync (rst_n_sync),
        .write_en   (write_en),
        .sense_en   (sense_en),
        .addr10 (a[10]), .addr9 (a[9]), .addr8 (a[8]), .addr7 (a[7]),
        .addr6  (a[6]),  .addr5 (a[5]), .addr4 (a[4]), .addr3 (a[3]),
        .addr2  (a[2]),  .addr1 (a[1]), .addr0 (a[0]),
        .din7 (d[7]), .din6 (d[6]), .din5 (d[5]), .din4 (d[4]),
        .din3 (d[3]), .din2 (d[2]), .din1 (d[1]), .din0 (d[0]),
        .dout7 (dout[7]), .dout6 (dout[6]), .dout5 (dout[5]), .dout4 (dout[4]),
        .dout3 (dout[3]), .dout2 (dout[2]), .dout1 (dout[1]), .dout0 (dout[0])
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: dout=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle's inputs, clock one rising edge, land 1 time unit after it.
    task automatic cyc(input logic we, input logic se, input addr_t ad, input data_t dd);
        write_en = we;
        sense_en = se;
        a        = ad;
        d        = dd;
        @(posedge clk_1);
        #1;
    endtask

    data_t wt_exp;

    initial begin
        // Reset state
        #2;
        check("reset_dout", dout, 8'h00);
        @(negedge clk_1);
        rst_n_sync = 1'b1;
        @(negedge clk_1);

        // Write A5 @000 (sense off): dout holds reset value
        cyc(1'b1, 1'b0, 11'h000, 8'hA5);
        check("write_hold", dout, 8'h00);
        cyc(1'b0, 1'b1, 11'h000, 8'h00);
        check("read_a5", dout, 8'hA5);

        // Sense off, address changes for 3 edges: dout holds
        cyc(1'b0, 1'b0, 11'h7FF, 8'h00);
        check("idle_hold_1", dout, 8'hA5);
        cyc(1'b0, 1'b0, 11'h123, 8'h00);
        check("idle_hold_2", dout, 8'hA5);
        cyc(1'b0, 1'b0, 11'h555, 8'h00);
        check("idle_hold_3", dout, 8'hA5);

        // Extreme addresses, no aliasing
        cyc(1'b1, 1'b0, 11'h7FF, 8'h3C);
        cyc(1'b1, 1'b0, 11'h000, 8'hC3);
        check("write_hold_2", dout, 8'hA5);
        cyc(1'b0, 1'b1, 11'h7FF, 8'h00);
        check("read_7ff", dout, 8'h3C);
        cyc(1'b0, 1'b1, 11'h000, 8'h00);
        check("read_000", dout, 8'hC3);

        // Walking address bits with distinct data
        for (int i = 0; i < 11; i++) begin
            cyc(1'b1, 1'b0, addr_t'(1 << i), data_t'(8'h10 + i));
        end
        for (int i = 0; i < 11; i++) begin
            cyc(1'b0, 1'b1, addr_t'(1 << i), 8'h00);
            check($sformatf("walk_%0d", i), dout, data_t'(8'h10 + i));
        end
        cyc(1'b0, 1'b1, 11'h000, 8'h00);
        check("walk_000_intact", dout, 8'hC3);

        // Consecutive writes, last wins; read right after the write
        cyc(1'b1, 1'b0, 11'h123, 8'h11);
        cyc(1'b1, 1'b0, 11'h123, 8'h22);
        cyc(1'b0, 1'b1, 11'h123, 8'h00);
        check("last_write_wins", dout, 8'h22);

        // Write edge with sense on
`ifdef SRAM_WRITE_THROUGH_EN
        wt_exp = 8'h5A;
`else
        wt_exp = 8'h22;
`endif
        cyc(1'b1, 1'b1, 11'h055, 8'h5A);
        check("write_sense_dout", dout, wt_exp);
        cyc(1'b0, 1'b1, 11'h055, 8'h00);
        check("read_5a", dout, 8'h5A);

        // Between-edge glitch on write_en has no effect
        write_en = 1'b0; sense_en = 1'b0; a = 11'h055; d = 8'hEE;
        #2 write_en = 1'b1;
        #2 write_en = 1'b0;
        cyc(1'b0, 1'b1, 11'h055, 8'h00);
        check("glitch_ignored", dout, 8'h5A);

        // Mid-cycle asynchronous reset, write attempted during reset
        #3 rst_n_sync = 1'b0;
        #1 check("async_reset", dout, 8'h00);
        cyc(1'b1, 1'b1, 11'h000, 8'hFF);
        check("reset_write_dout", dout, 8'h00);
        write_en = 1'b0;
        sense_en = 1'b0;
        #2 rst_n_sync = 1'b1;
        @(negedge clk_1);
        cyc(1'b0, 1'b1, 11'h000, 8'h00);
        check("after_reset_000", dout, 8'hC3);
        cyc(1'b0, 1'b1, 11'h7FF, 8'h00);
        check("after_reset_7ff", dout, 8'h3C);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_sram_compiled_array

// File: doc/sram_compiled_array.md
SRAM_COMPILED_ARRAY -- requirements
Module: sram_compiled_array

Interface
REQ-001 Parameter ADDR_W, default 11, address width in bits.
REQ-002 Parameter DATA_W, default 8, data width in bits.
REQ-003 Parameter DEPTH, default 2048 (2**ADDR_W), number of words.
REQ-004 Port clk_1  input  1  array clock; all sampling on its rising edge.
REQ-005 Port rst_n_sync  input  1  reset, asynchronous, active-low.
REQ-006 Port write_en  input  1  1 = write din to addr on the clock edge.
REQ-007 Port sense_en  input  1  1 = sense (read) enable; dout updates only when set.
REQ-008 Port addr10..addr0  input  1 each  word address, addr0 = LSB.
REQ-009 Port din7..din0  input  1 each  write data, din0 = LSB.
REQ-010 Port dout7..dout0  output  1 each  registered read data, dout0 = LSB.

Function
REQ-011 Storage SHALL be DEPTH x DATA_W words, fully addressed by {addr10..addr0}; there are no out-of-range addresses and no aliasing.
REQ-012 Write: on rising clk_1 with rst_n_sync=1 and write_en=1, mem[addr] <= din, regardless of sense_en.
REQ-013 Read: on rising clk_1 with write_en=0 and sense_en=1, dout <= mem[addr]; latency 1 clock edge, synchronous-read only.
REQ-014 Idle: with write_en=0 and sense_en=0, dout and memory SHALL hold.
REQ-015 Write cycle output: dout behaviour is set by REQ-021/REQ-022; the old stored word is never driven out during a write.
REQ-016 Consecutive writes to one address SHALL each take effect on their own edge; last write wins.
REQ-017 A read on the edge immediately after a write to the same address SHALL return the newly written data.
REQ-018 Inputs are sampled only at the rising edge; changes between edges have no effect.

Reset
REQ-019 While rst_n_sync=0, dout SHALL be 8'h00 immediately (asynchronous) and writes SHALL be blocked.
REQ-020 Reset SHALL NOT clear the storage array; contents written before reset are readable after release.

Configuration
REQ-021 With SRAM_WRITE_THROUGH_EN defined: on a write edge with sense_en=1, dout <= din (write-first); with sense_en=0, dout holds.
REQ-022 Without SRAM_WRITE_THROUGH_EN: dout holds its previous value on every write edge.

Structure
REQ-023 Package sram_compiled_pkg SHALL hold ADDR_W, DATA_W and DEPTH constants plus addr_t/data_t typedefs.
REQ-024 Top SHALL pack the discrete bit ports into addr/din vectors and unpack dout; storage lives in one sub-module, sram_compiled_core (vector ports, clk_1, rst_n_sync, write_en, sense_en).
REQ-025 Two to four sram_compiled_array instances SHALL be usable side by side sharing addr/clock/enables to form wider words.

Verification
REQ-026 Write 8'hA5 to addr 11'h000, then read (write_en=0, sense_en=1) -> dout=8'hA5 after one edge.
REQ-027 Write 8'h3C to 11'h7FF and 8'hC3 to 11'h000; read 11'h7FF -> 8'h3C, read 11'h000 -> 8'hC3 (no aliasing).
REQ-028 After a read of 8'hA5, hold sense_en=0 and change addr for 3 edges -> dout stays 8'hA5.
REQ-029 Assert rst_n_sync mid-cycle -> dout=8'h00 at once; write attempt during reset ignored; after release, read 11'h000 -> 8'hC3.
REQ-030 With SRAM_WRITE_THROUGH_EN, write 8'h5A with sense_en=1 -> dout=8'h5A same edge; without the macro -> dout unchanged.
